// File: rtl/addsub_nibble_seq_if.sv
// Handshake bundle for addsub_nibble_seq: operand request side and result side.
// out_ovf is present only when ADDSUB_OVF_EN is defined.
interface addsub_nibble_seq_if #(
  parameter int unsigned NIBBLES = 4
);
  localparam int unsigned W = 4 * NIBBLES;

  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] in_a;
  logic [W-1:0] in_b;
  logic         in_m;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] out_s;
  logic         out_carry;
`ifdef ADDSUB_OVF_EN
  logic         out_ovf;
`endif

  modport master (
    output in_valid, in_a, in_b, in_m, out_ready,
    input  in_ready, out_valid, out_s, out_carry
`ifdef ADDSUB_OVF_EN
    , input out_ovf
`endif
  );

  modport slave (
    input  in_valid, in_a, in_b, in_m, out_ready,
    output in_ready, out_valid, out_s, out_carry
`ifdef ADDSUB_OVF_EN
    , output out_ovf
`endif
  );
endinterface

// File: rtl/addsub_nibble_seq.sv
// Nibble-serial W-bit add/subtract sequencer, one 4-bit slice per clock, LSB first.
// Define ADDSUB_OVF_EN to add the registered signed-overflow output out_ovf.
module addsub_nibble_seq #(
  parameter int unsigned NIBBLES = 4
) (
  input  logic               clk,
  input  logic               rst,
  addsub_nibble_seq_if.slave bus
);
  localparam int unsigned W  = 4 * NIBBLES;
  localparam int unsigned IW = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t         state_q, state_d;
  logic [W-1:0]   a_q, a_d;
  logic [W-1:0]   bx_q, bx_d;
  logic [W-1:0]   res_q, res_d;
  logic [IW-1:0]  idx_q, idx_d;
  logic           carry_q, carry_d;
  logic           out_valid_q, out_valid_d;
  logic [W-1:0]   out_s_q, out_s_d;
  logic           out_carry_q, out_carry_d;
`ifdef ADDSUB_OVF_EN
  logic           out_ovf_q, out_ovf_d;
`endif

  logic [IW+1:0]  base;
  logic [4:0]     sum;
  logic [W-1:0]   res_full;

  // Current slice sum and the working result with that slice merged in
  always_comb begin
    base     = {idx_q, 2'b00};
    sum      = {1'b0, a_q[base +: 4]} + {1'b0, bx_q[base +: 4]} + {4'd0, carry_q};
    res_full = res_q;
    res_full[base +: 4] = sum[3:0];
  end

  always_comb begin
    state_d     = state_q;
    a_d         = a_q;
    bx_d        = bx_q;
    res_d       = res_q;
    idx_d       = idx_q;
    carry_d     = carry_q;
    out_valid_d = out_valid_q;
    out_s_d     = out_s_q;
    out_carry_d = out_carry_q;
`ifdef ADDSUB_OVF_EN
    out_ovf_d   = out_ovf_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (bus.in_valid) begin
          a_d     = bus.in_a;
          bx_d    = bus.in_b ^ {W{bus.in_m}};
          carry_d = bus.in_m;
          idx_d   = '0;
          res_d   = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        res_d   = res_full;
        carry_d = sum[4];
        idx_d   = idx_q + 1'b1;
        if (idx_q == IW'(NIBBLES - 1)) begin
          idx_d       = '0;
          out_s_d     = res_full;
          out_carry_d = sum[4];
`ifdef ADDSUB_OVF_EN
          out_ovf_d   = (a_q[W-1] ~^ bx_q[W-1]) & (res_full[W-1] ^ a_q[W-1]);
`endif
          out_valid_d = 1'b1;
          state_d     = DONE;
        end
      end
      DONE: begin
        if (bus.out_ready) begin
          out_valid_d = 1'b0;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      a_q         <= '0;
      bx_q        <= '0;
      res_q       <= '0;
      idx_q       <= '0;
      carry_q     <= 1'b0;
      out_valid_q <= 1'b0;
      out_s_q     <= '0;
      out_carry_q <= 1'b0;
`ifdef ADDSUB_OVF_EN
      out_ovf_q   <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      a_q         <= a_d;
      bx_q        <= bx_d;
      res_q       <= res_d;
      idx_q       <= idx_d;
      carry_q     <= carry_d;
      out_valid_q <= out_valid_d;
      out_s_q     <= out_s_d;
      out_carry_q <= out_carry_d;
`ifdef ADDSUB_OVF_EN
      out_ovf_q   <= out_ovf_d;
`endif
    end
  end

  assign bus.in_ready  = (state_q == IDLE) & ~rst;
  assign bus.out_valid = out_valid_q;
  assign bus.out_s     = out_s_q;
  assign bus.out_carry = out_carry_q;
`ifdef ADDSUB_OVF_EN
  assign bus.out_ovf   = out_ovf_q;
`endif
endmodule
